// File: rtl/perm_pkg.sv
// Shared sizing and helpers for the permutation state gatherer.
// Modules take their own parameters; these are the default geometry.
package perm_pkg;

    localparam int CHUNK_W = 200;
    localparam int NCHUNK  = 8;
    localparam int IX_W    = 3;
    localparam int TAG_W   = 8;
    localparam int STATE_W = CHUNK_W * NCHUNK;

    // Low bit of chunk k within an assembled state
    function automatic int chunk_lo(input int k, input int w = CHUNK_W);
        return k * w;
    endfunction

endpackage

// File: rtl/perm_gather_bank.sv
// One ping-pong bank: collects indexed chunks in any order, marks itself full
// and latches its tag once every chunk has arrived, and empties on drain.
module perm_gather_bank #(
    parameter int CW  = perm_pkg::CHUNK_W,
    parameter int NC  = perm_pkg::NCHUNK,
    parameter int IXW = perm_pkg::IX_W,
    parameter int TW  = perm_pkg::TAG_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [IXW-1:0]   dix,
    input  logic [CW-1:0]    din,
    input  logic [TW-1:0]    tag_in,
    input  logic             drain,
    output logic             complete,
    output logic             full,
    output logic [CW*NC-1:0] data,
    output logic [TW-1:0]    tag
);
    import perm_pkg::*;

    logic [CW*NC-1:0] data_r;
    logic [NC-1:0]    bitmap_r;
    logic             full_r;
    logic [TW-1:0]    tag_r;
    logic [NC-1:0]    bitmap_set_s;

    // Arrival bitmap as it will look once the chunk being written lands
    always_comb begin
        bitmap_set_s = bitmap_r;
        for (int k = 0; k < NC; k++) begin
            if (wr_en && (dix == IXW'(k))) begin
                bitmap_set_s[k] = 1'b1;
            end else begin
                bitmap_set_s[k] = bitmap_r[k];
            end
        end
    end

    assign complete = wr_en & (&bitmap_set_s);

    // Chunk writes, completion bookkeeping and release on drain
    always_ff @(posedge clk) begin
        if (reset) begin
            data_r   <= {(CW*NC){1'b0}};
            bitmap_r <= {NC{1'b0}};
            full_r   <= 1'b0;
            tag_r    <= {TW{1'b0}};
        end else begin
            for (int k = 0; k < NC; k++) begin
                if (wr_en && (dix == IXW'(k))) begin
                    data_r[chunk_lo(k, CW) +: CW] <= din;
                end
            end
            // A bank is never written while full, so completion and drain
            // cannot hit the same bank in one cycle.
            if (complete) begin
                bitmap_r <= {NC{1'b0}};
                full_r   <= 1'b1;
                tag_r    <= tag_in;
            end else begin
                bitmap_r <= bitmap_set_s;
                if (drain) begin
                    full_r <= 1'b0;
                end
            end
        end
    end

    assign full = full_r;
    assign data = data_r;
    assign tag  = tag_r;

endmodule

// File: rtl/perm_state_gather.sv
// Double-buffered gatherer: assembles indexed chunks into full permutation
// states, tags them sequentially and hands them to the core in order.
module perm_state_gather #(
    parameter int CHUNK_W = perm_pkg::CHUNK_W,
    parameter int NCHUNK  = perm_pkg::NCHUNK,
    parameter int IX_W    = perm_pkg::IX_W,
    parameter int TAG_W   = perm_pkg::TAG_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      pushin,
    input  logic [IX_W-1:0]           dix,
    input  logic [CHUNK_W-1:0]        din,
    output logic                      stopout,
    output logic                      pushout,
    input  logic                      stopin,
    output logic [CHUNK_W*NCHUNK-1:0] dout,
    output logic [TAG_W-1:0]          tagout,
    output logic                      err
);
    import perm_pkg::*;

    localparam int SW = CHUNK_W * NCHUNK;

    logic             wr_ptr_r;
    logic             rd_ptr_r;
    logic [TAG_W-1:0] tag_cnt_r;
    logic             err_r;
    logic             ix_ok_s;
    logic             accept_s;
    logic             drain_s;
    logic             complete_s;
    logic [1:0]       bank_complete_s;
    logic [1:0]       bank_full_s;
    logic [SW-1:0]    bank_data_s [2];
    logic [TAG_W-1:0] bank_tag_s [2];

    assign ix_ok_s    = ({1'b0, dix} < (IX_W + 1)'(NCHUNK));
    assign stopout    = bank_full_s[wr_ptr_r];
    assign pushout    = bank_full_s[rd_ptr_r];
    assign accept_s   = pushin & ~stopout & ix_ok_s;
    assign drain_s    = pushout & ~stopin;
    assign complete_s = |bank_complete_s;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        perm_gather_bank #(
            .CW  (CHUNK_W),
            .NC  (NCHUNK),
            .IXW (IX_W),
            .TW  (TAG_W)
        ) u_bank (
            .clk      (clk),
            .reset    (reset),
            .wr_en    (accept_s & (wr_ptr_r == 1'(b))),
            .dix      (dix),
            .din      (din),
            .tag_in   (tag_cnt_r),
            .drain    (drain_s & (rd_ptr_r == 1'(b))),
            .complete (bank_complete_s[b]),
            .full     (bank_full_s[b]),
            .data     (bank_data_s[b]),
            .tag      (bank_tag_s[b])
        );
    end

    // Fill/drain pointers, wrapping tag counter and sticky error
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r  <= 1'b0;
            rd_ptr_r  <= 1'b0;
            tag_cnt_r <= {TAG_W{1'b0}};
            err_r     <= 1'b0;
        end else begin
            if (complete_s) begin
                wr_ptr_r  <= ~wr_ptr_r;
                tag_cnt_r <= tag_cnt_r + TAG_W'(1);
            end
            if (drain_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            if (pushin && (stopout || !ix_ok_s)) begin
                err_r <= 1'b1;
            end
        end
    end

    assign dout   = rd_ptr_r ? bank_data_s[1] : bank_data_s[0];
    assign tagout = rd_ptr_r ? bank_tag_s[1] : bank_tag_s[0];
    assign err    = err_r;

endmodule

// File: tb/tb_perm_state_gather.sv
// Directed bench: a default-geometry instance (a_*) and a small instance with
// NCHUNK=5, TAG_W=2 (b_*), each checked against a queue of expected states.
module tb_perm_state_gather;
    import perm_pkg::*;

    localparam int CW2 = 8;
    localparam int NC2 = 5;
    localparam int IX2 = 3;
    localparam int TW2 = 2;

    typedef struct {
        logic [STATE_W-1:0] data;
        logic [7:0]         tag;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    logic                 a_pushin, a_stopin, a_stopout, a_pushout, a_err;
    logic [IX_W-1:0]      a_dix;
    logic [CHUNK_W-1:0]   a_din;
    logic [STATE_W-1:0]   a_dout;
    logic [TAG_W-1:0]     a_tagout;

    logic                 b_pushin, b_stopin, b_stopout, b_pushout, b_err;
    logic [IX2-1:0]       b_dix;
    logic [CW2-1:0]       b_din;
    logic [CW2*NC2-1:0]   b_dout;
    logic [TW2-1:0]       b_tagout;

    exp_t               qa[$];
    exp_t               qb[$];
    logic [STATE_W-1:0] m_data [2];
    logic [7:0]         m_bmp [2];
    int                 m_tag [2];
    int                 ooo [9];
    int                 errors = 0;
    int                 checks = 0;
    int                 a_outs = 0;
    int                 b_outs = 0;

    always #5 clk = ~clk;

    perm_state_gather u_dut_a (
        .clk(clk), .reset(reset), .pushin(a_pushin), .dix(a_dix), .din(a_din),
        .stopout(a_stopout), .pushout(a_pushout), .stopin(a_stopin),
        .dout(a_dout), .tagout(a_tagout), .err(a_err)
    );

    perm_state_gather #(.CHUNK_W(CW2), .NCHUNK(NC2), .IX_W(IX2), .TAG_W(TW2)) u_dut_b (
        .clk(clk), .reset(reset), .pushin(b_pushin), .dix(b_dix), .din(b_din),
        .stopout(b_stopout), .pushout(b_pushout), .stopin(b_stopin),
        .dout(b_dout), .tagout(b_tagout), .err(b_err)
    );

    task automatic check(input string name, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Drive one chunk for a cycle and advance the reference model
    task automatic push(input int sel, input int ix, input logic [CHUNK_W-1:0] d, input bit drop);
        int         nc;
        int         cw;
        logic [7:0] full_mask;
        exp_t       e;
        nc        = (sel == 0) ? NCHUNK : NC2;
        cw        = (sel == 0) ? CHUNK_W : CW2;
        full_mask = (sel == 0) ? 8'hFF : 8'h1F;
        if (sel == 0) begin
            a_pushin = 1'b1; a_dix = IX_W'(ix); a_din = d;
        end else begin
            b_pushin = 1'b1; b_dix = IX2'(ix); b_din = d[CW2-1:0];
        end
        if (!drop && ix < nc) begin
            for (int i = 0; i < cw; i++) m_data[sel][ix*cw + i] = d[i];
            m_bmp[sel][ix] = 1'b1;
            if (m_bmp[sel] == full_mask) begin
                e.data = m_data[sel];
                e.tag  = 8'(m_tag[sel]);
                if (sel == 0) qa.push_back(e);
                else qb.push_back(e);
                m_tag[sel] = (m_tag[sel] + 1) % ((sel == 0) ? 256 : 4);
                m_bmp[sel] = 8'h00;
            end
        end
        @(posedge clk); #1;
        a_pushin = 1'b0;
        b_pushin = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        qa.delete();
        qb.delete();
        for (int s = 0; s < 2; s++) begin
            m_data[s] = '0; m_bmp[s] = 8'h00; m_tag[s] = 0;
        end
    endtask

    // Scoreboard for instance a: each transferred state must match the oldest expectation
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (!reset && a_pushout && !a_stopin) begin
            a_outs++;
            if (qa.size() == 0) begin
                check("a_spurious_pushout", 256'(a_pushout), 256'(0));
            end else begin
                e = qa.pop_front();
                for (int k = 0; k < NCHUNK; k++)
                    check($sformatf("a_chunk%0d", k), 256'(a_dout[k*CHUNK_W +: CHUNK_W]),
                          256'(e.data[k*CHUNK_W +: CHUNK_W]));
                check("a_tag", 256'(a_tagout), 256'(e.tag));
            end
        end
    end

    // Scoreboard for instance b
    always @(negedge clk) begin : mon_b
        exp_t e;
        if (!reset && b_pushout && !b_stopin) begin
            b_outs++;
            if (qb.size() == 0) begin
                check("b_spurious_pushout", 256'(b_pushout), 256'(0));
            end else begin
                e = qb.pop_front();
                for (int k = 0; k < NC2; k++)
                    check($sformatf("b_chunk%0d", k), 256'(b_dout[k*CW2 +: CW2]),
                          256'(e.data[k*CW2 +: CW2]));
                check("b_tag", 256'(b_tagout), 256'(e.tag));
            end
        end
    end

    initial begin
        reset = 1'b1;
        a_pushin = 1'b0; a_stopin = 1'b0; a_dix = '0; a_din = '0;
        b_pushin = 1'b0; b_stopin = 1'b0; b_dix = '0; b_din = '0;
        ooo = '{5, 2, 2, 7, 0, 1, 3, 6, 4};
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        check("rst_pushout", 256'(a_pushout), 256'(0));
        check("rst_stopout", 256'(a_stopout), 256'(0));
        check("rst_err", 256'(a_err), 256'(0));
        check("rst_dout", 256'(|a_dout), 256'(0));
        check("rst_tagout", 256'(a_tagout), 256'(0));
        check("rst_b_pushout", 256'(b_pushout), 256'(0));

        // In-order fill
        for (int k = 0; k < NCHUNK; k++) push(0, k, {25{8'(k)}}, 1'b0);
        check("io_latency", 256'(a_pushout), 256'(1));
        check("io_tag", 256'(a_tagout), 256'(0));
        @(posedge clk); #1;
        check("io_single_pulse", 256'(a_pushout), 256'(0));
        check("io_outs", 256'(a_outs), 256'(1));

        // Out-of-order with a duplicate index
        for (int i = 0; i < 8; i++) push(0, ooo[i], {25{8'(8'h40 + i)}}, 1'b0);
        check("ooo_not_early", 256'(a_pushout), 256'(0));
        push(0, ooo[8], {25{8'h48}}, 1'b0);
        check("ooo_pushout", 256'(a_pushout), 256'(1));
        check("ooo_err", 256'(a_err), 256'(0));
        @(posedge clk); #1;
        check("ooo_outs", 256'(a_outs), 256'(2));

        // Backpressure: two states held, third push refused
        do_reset();
        a_stopin = 1'b1;
        for (int i = 0; i < 16; i++) begin
            push(0, i % 8, {25{8'(8'h80 + i)}}, 1'b0);
            if (i == 7) check("bp_one_bank_free", 256'(a_stopout), 256'(0));
        end
        check("bp_stopout", 256'(a_stopout), 256'(1));
        check("bp_hold_tag", 256'(a_tagout), 256'(0));
        push(0, 3, {25{8'hFF}}, 1'b1);
        check("bp_err", 256'(a_err), 256'(1));
        check("bp_still_stopped", 256'(a_stopout), 256'(1));
        check("bp_hold_tag2", 256'(a_tagout), 256'(0));
        a_stopin = 1'b0;
        @(posedge clk); #1;
        check("bp_stopout_fall", 256'(a_stopout), 256'(0));
        check("bp_second_ready", 256'(a_pushout), 256'(1));
        check("bp_second_tag", 256'(a_tagout), 256'(1));
        @(posedge clk); #1;
        check("bp_drained", 256'(a_pushout), 256'(0));
        check("bp_outs", 256'(a_outs), 256'(4));

        // Reset mid-fill discards the partial state
        for (int i = 0; i < 4; i++) push(0, i, {25{8'(8'hC0 + i)}}, 1'b0);
        do_reset();
        check("mr_pushout", 256'(a_pushout), 256'(0));
        check("mr_err", 256'(a_err), 256'(0));
        check("mr_tag", 256'(a_tagout), 256'(0));
        for (int i = 0; i < 8; i++) begin
            push(0, (i + 4) % 8, {25{8'(8'hD0 + i)}}, 1'b0);
            if (i == 3) check("mr_no_stale_complete", 256'(a_pushout), 256'(0));
        end
        check("mr_pushout_new", 256'(a_pushout), 256'(1));
        @(posedge clk); #1;
        check("mr_outs", 256'(a_outs), 256'(5));

        // Tag wrap on the small instance
        for (int s = 0; s < 5; s++)
            for (int k = 0; k < NC2; k++) push(1, k, CHUNK_W'(8'(s * 16 + k)), 1'b0);
        @(posedge clk); #1;
        check("wrap_outs", 256'(b_outs), 256'(5));
        check("wrap_queue", 256'(qb.size()), 256'(0));

        // Out-of-range index is dropped and flagged
        for (int k = 0; k < 4; k++) push(1, k, CHUNK_W'(8'(8'hA0 + k)), 1'b0);
        push(1, 6, CHUNK_W'(8'hEE), 1'b0);
        check("badix_err", 256'(b_err), 256'(1));
        check("badix_no_complete", 256'(b_pushout), 256'(0));
        push(1, 4, CHUNK_W'(8'hA4), 1'b0);
        check("badix_complete", 256'(b_pushout), 256'(1));
        @(posedge clk); #1;
        check("badix_outs", 256'(b_outs), 256'(6));
        check("badix_err_sticky", 256'(b_err), 256'(1));
        check("a_queue_empty", 256'(qa.size()), 256'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
